// File: rtl/button_mode_ctrl_pkg.sv
// Shared constants for the button/mode controller: mode encodings, button roles, default debounce depth.
package button_mode_ctrl_pkg;

  localparam int unsigned NUM_BTN                 = 4;
  localparam int unsigned ADV                     = 0;
  localparam int unsigned HOME                    = 1;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN_A = 2'b01,
    RUN_B = 2'b10,
    RUN_C = 2'b11
  } mode_e;

  // Advance order of the operating modes, wrapping RUN_C back to IDLE.
  function automatic mode_e advance_mode(input mode_e m);
    mode_e r;
    case (m)
      IDLE:    r = RUN_A;
      RUN_A:   r = RUN_B;
      RUN_B:   r = RUN_C;
      default: r = IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One push-button channel: 2-flop synchronizer, optional debounce filter (DEBOUNCE_EN), rising-edge flag.
// Without DEBOUNCE_EN the synchronizer output is the stable level and no counter is built.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic sync1;
  logic sync2;

  if (DEBOUNCE_CYCLES < 2 ||
      (CNT_W < 64 && 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_cfg
    $error("debounce_bit: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;

  // Count while the synchronized level disagrees; any agreement restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level;
    if (sync2 != level) begin
      if (cnt_q == TERM) begin
        level_d = sync2;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      level <= level_d;
      rise  <= level_d & ~level;
    end
  end
`else
  assign level = sync2;

  // Rise flag lands on the same edge the synchronizer output goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
    end else begin
      rise <= sync1 & ~sync2;
    end
  end
`endif

endmodule

// File: rtl/button_mode_ctrl.sv
// Four debounced push-buttons with press pulses driving a 4-state operating-mode FSM.
// Debounce filtering is built only when DEBOUNCE_EN is defined.
module button_mode_ctrl
  import button_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [NUM_BTN-1:0] buttons_raw_i,
  output logic [NUM_BTN-1:0] buttons_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [1:0]         mode_o,
  output logic               mode_chg_o
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clock_i),
      .rst_n(reset_i),
      .raw  (buttons_raw_i[i]),
      .level(buttons_o[i]),
      .rise (press_o[i])
    );
  end

  mode_e mode_q;
  mode_e mode_d;
  logic  mode_chg_d;

  // HOME overrides ADV; buttons 2 and 3 are ignored by the mode logic.
  always_comb begin
    mode_d     = mode_q;
    mode_chg_d = 1'b0;
    if (press_o[HOME]) begin
      mode_d = IDLE;
    end else if (press_o[ADV]) begin
      mode_d = advance_mode(mode_q);
    end
    mode_chg_d = (mode_d != mode_q);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      mode_q     <= IDLE;
      mode_chg_o <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      mode_chg_o <= mode_chg_d;
    end
  end

  assign mode_o = mode_q;

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Self-checking bench for button_mode_ctrl (DEBOUNCE_CYCLES=4); follows DEBOUNCE_EN like the RTL.
module tb_button_mode_ctrl;
  import button_mode_ctrl_pkg::*;

  localparam int unsigned DC = 4;
`ifdef DEBOUNCE_EN
  localparam int unsigned LAT = 2 + DC;
`else
  localparam int unsigned LAT = 2;
`endif
  localparam int unsigned NROWS = 16;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b0;
  logic [3:0] buttons_raw_i = 4'b0000;
  logic [3:0] buttons_o;
  logic [3:0] press_o;
  logic [1:0] mode_o;
  logic       mode_chg_o;

  int n_vec = 0;
  int n_bad = 0;

  button_mode_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (8)
  ) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .buttons_raw_i(buttons_raw_i),
    .buttons_o    (buttons_o),
    .press_o      (press_o),
    .mode_o       (mode_o),
    .mode_chg_o   (mode_chg_o)
  );

  always #5 clock_i = ~clock_i;

  // Reference model: raw sample history, window-based acceptance, modulo-4 mode counter.
  logic [3:0] rq[$];
  logic [3:0] sq[$];
  logic [3:0] m_stable;
  logic [3:0] m_press;
  int         m_mode;
  logic       m_chg;

  task automatic model_reset();
    rq.delete();
    sq.delete();
    rq.push_back(4'b0000);
    rq.push_back(4'b0000);
    for (int i = 0; i < int'(DC) + 1; i++) sq.push_back(4'b0000);
    m_stable = 4'b0000;
    m_press  = 4'b0000;
    m_mode   = 0;
    m_chg    = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] raw);
    int         nm;
    logic [3:0] s;
    logic [3:0] ns;
    nm = m_press[HOME] ? 0 : (m_press[ADV] ? (m_mode + 1) % 4 : m_mode);
    m_chg  = (nm != m_mode);
    m_mode = nm;
    rq.push_back(raw);
    s = rq[rq.size() - 2];
    void'(rq.pop_front());
    sq.push_back(s);
`ifdef DEBOUNCE_EN
    ns = m_stable;
    for (int b = 0; b < 4; b++) begin
      logic v;
      logic held;
      v    = sq[sq.size() - 2][b];
      held = 1'b1;
      for (int j = 1; j <= int'(DC); j++)
        if (sq[sq.size() - 1 - j][b] != v) held = 1'b0;
      if (held && v != m_stable[b]) ns[b] = v;
    end
`else
    ns = s;
`endif
    void'(sq.pop_front());
    m_press  = ns & ~m_stable;
    m_stable = ns;
  endtask

  always @(posedge clock_i) if (reset_i) model_edge(buttons_raw_i);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model {btn,press,mode,chg}",
          32'({buttons_o, press_o, mode_o, mode_chg_o}),
          32'({m_stable, m_press, 2'(m_mode), m_chg}));
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
    check_model();
  endtask

  task automatic step(input logic [3:0] raw);
    @(negedge clock_i);
    buttons_raw_i = raw;
    tick();
  endtask

  task automatic tap(input logic [3:0] m);
    repeat (LAT + 2) step(m);
    repeat (LAT + 2) step(4'b0000);
  endtask

  // Async reset dropped mid-cycle; everything must clear at once.
  task automatic mid_reset(input string name);
    reset_i = 1'b0;
    #1;
    check(name, 32'({buttons_o, press_o, mode_o, mode_chg_o}), 32'd0);
    model_reset();
    @(negedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b1;
  endtask

  typedef struct {
    logic [3:0] raw;
    logic [3:0] btn;
    logic [3:0] press;
    logic [1:0] mode;
    logic       chg;
  } vec_t;

  vec_t tbl[NROWS];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         found;
    logic       any_chg;
    logic       saw_home;
    logic [3:0] r;

    // Press-and-release of button 0 from reset, one row per clock edge.
    for (int k = 1; k <= int'(NROWS); k++) begin
      tbl[k-1].raw   = (k <= 8) ? 4'b0001 : 4'b0000;
      tbl[k-1].btn   = (k >= int'(LAT) && k < 8 + int'(LAT)) ? 4'b0001 : 4'b0000;
      tbl[k-1].press = (k == int'(LAT)) ? 4'b0001 : 4'b0000;
      tbl[k-1].mode  = (k >= int'(LAT) + 1) ? 2'b01 : 2'b00;
      tbl[k-1].chg   = (k == int'(LAT) + 1);
    end

    model_reset();
    #1;
    check("reset_state", 32'({buttons_o, press_o, mode_o, mode_chg_o}), 32'd0);
    @(negedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b1;

    for (int k = 0; k < int'(NROWS); k++) begin
      step(tbl[k].raw);
      check($sformatf("table row %0d", k + 1),
            32'({buttons_o, press_o, mode_o, mode_chg_o}),
            32'({tbl[k].btn, tbl[k].press, tbl[k].mode, tbl[k].chg}));
    end

    tap(4'b0001);
    tap(4'b0001);
    check("reach RUN_C", 32'(mode_o), 32'd3);
    tap(4'b0001);
    check("wrap RUN_C->IDLE", 32'(mode_o), 32'd0);
    tap(4'b0001);
    check("advance to RUN_A", 32'(mode_o), 32'd1);
    tap(4'b0011);
    check("HOME beats ADV", 32'(mode_o), 32'd0);

    any_chg  = 1'b0;
    saw_home = 1'b0;
    repeat (LAT + 2) begin
      step(4'b0010);
      any_chg  = any_chg | mode_chg_o;
      saw_home = saw_home | press_o[HOME];
    end
    check("HOME press seen in IDLE", 32'(saw_home), 32'd1);
    check("no mode_chg for HOME in IDLE", 32'(any_chg), 32'd0);
    repeat (LAT + 2) step(4'b0000);

    tap(4'b0001);
    tap(4'b0001);
    check("reach RUN_B", 32'(mode_o), 32'd2);
    for (int k = 1; k <= int'(LAT) + 1; k++) begin
      step(4'b0010);
      if (k == int'(LAT) - 1) check("btn1 before latency", 32'(buttons_o[1]), 32'd0);
      if (k == int'(LAT)) check("btn1 at latency", 32'(buttons_o[1]), 32'd1);
      if (k == int'(LAT) + 1) check("RUN_B->IDLE on HOME", 32'(mode_o), 32'd0);
    end
    repeat (LAT + 2) step(4'b0000);

`ifdef DEBOUNCE_EN
    for (int i = 0; i < 40; i++) begin
      step(((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000);
      check("bounce filtered", 32'({buttons_o, press_o}), 32'd0);
    end
    repeat (LAT + 2) step(4'b0000);
`endif

    tap(4'b0001);
    check("RUN_A before reset", 32'(mode_o), 32'd1);
    repeat (4) step(4'b0001);
    mid_reset("reset mid-debounce clears");
    found = 0;
    for (int k = 1; k <= int'(LAT) + 10; k++) begin
      tick();
      if (press_o[0] && found == 0) found = k;
    end
    check("press latency after reset", 32'(found), 32'(LAT));
    repeat (LAT + 2) step(4'b0000);

    r = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
      step(r);
      if ($urandom_range(0, 399) == 0) mid_reset("random reset clears");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
